// File: rtl/pix_stream_tx_pkg.sv
// pix_stream_tx_pkg: shared frame geometry, prime depth and FSM encoding for the pixel streamer and filter
package pix_stream_tx_pkg;
  localparam int IMG_W_DEF = 512;
  localparam int IMG_H_DEF = 512;
  localparam int PRIME_DEF = 514;
  localparam int GAP_DEF = 12;
  localparam int CW = 19;
  localparam int AW = 18;
  localparam int DW = 16;
  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_STEADY, S_DRAIN, S_FIN} state_t;
  function automatic logic [CW-1:0] frame_px(int w, int h);
    return CW'(w * h);
  endfunction
endpackage

// File: rtl/pix_stream_tx_if.sv
// pix_stream_tx_if: frame-memory read port plus pixel stream to the filter and its result strobe
interface pix_stream_tx_if;
  import pix_stream_tx_pkg::*;
  logic mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] dout;
  logic o_en;
  logic ack;
  modport master(output mem_rd, mem_addr, dout, o_en, input mem_rdata, ack);
  modport slave(input mem_rd, mem_addr, dout, o_en, output mem_rdata, ack);
endinterface

// File: rtl/pix_stream_tx_gap_timer.sv
// gap_timer: down-counter reloaded on each issue; expired once GAP cycles have passed since the last load
module gap_timer #(
  parameter int GAP = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);
  localparam int W = $clog2(GAP + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= W'(GAP - 1);
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign expired = (cnt == '0);
endmodule

// File: rtl/pix_stream_tx.sv
// pix_stream_tx: streams a frame from memory to the filter, pacing issues by GAP and by filter ack credits
module pix_stream_tx
  import pix_stream_tx_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PRIME = PRIME_DEF,
  parameter int GAP = GAP_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  pix_stream_tx_if.master bus,
  output logic busy,
  output logic done
);
  localparam logic [CW-1:0] TOTAL = frame_px(IMG_W, IMG_H);
  localparam logic [CW-1:0] PRIME_N = CW'(PRIME);
  state_t state, state_nx;
  logic [CW-1:0] sent, acks, credit;
  logic issue, gap_ok, rd_d1, ack_in, steady;
  gap_timer #(.GAP(GAP)) u_gap (.clk(clk), .rst(rst), .load(issue), .expired(gap_ok));
  always_comb begin
    state_nx = state;
    issue = 1'b0;
    case (state)
      S_IDLE: state_nx = start ? S_PRIME : S_IDLE;
      S_PRIME: begin
        issue = gap_ok && sent < PRIME_N && sent < TOTAL;
        state_nx = sent >= TOTAL ? S_DRAIN : sent == PRIME_N ? S_STEADY : S_PRIME;
      end
      S_STEADY: begin
        issue = gap_ok && credit != '0 && sent < TOTAL;
        state_nx = sent >= TOTAL ? S_DRAIN : S_STEADY;
      end
      S_DRAIN: state_nx = acks == TOTAL ? S_FIN : S_DRAIN;
      default: state_nx = S_IDLE;
    endcase
  end
  assign steady = (state == S_STEADY);
  assign ack_in = bus.ack && state inside {S_PRIME, S_STEADY, S_DRAIN} && acks != TOTAL;
  assign busy = state inside {S_PRIME, S_STEADY, S_DRAIN};
  assign done = (state == S_FIN);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sent <= '0;
      acks <= '0;
      credit <= '0;
      bus.mem_rd <= 1'b0;
      bus.mem_addr <= '0;
      rd_d1 <= 1'b0;
      bus.o_en <= 1'b0;
      bus.dout <= '0;
    end else begin
      state <= state_nx;
      bus.mem_rd <= issue;
      rd_d1 <= bus.mem_rd;
      bus.o_en <= rd_d1;
      if (rd_d1) bus.dout <= bus.mem_rdata;
      if (state == S_IDLE && start) begin
        sent <= '0;
        acks <= '0;
        credit <= '0;
      end else begin
        if (issue) sent <= sent + 1'b1;
        if (issue) bus.mem_addr <= sent[AW-1:0];
        if (ack_in) acks <= acks + 1'b1;
        credit <= credit + CW'(steady && bus.ack) - CW'(steady && issue);
      end
    end
  end
endmodule
